cm82_vector_sequencer: RTL and testbench

CM82_VECTOR_SEQUENCER -- requirements
Module: cm82_vector_sequencer

---
 rtl/cm82_vector_sequencer.sv | 126 ++++++++++++
 tb/tb_cm82_vector_sequencer.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cm82_vector_sequencer.sv
// Purpose: buffers 5-bit operand vectors in a FIFO, drives the head into an external
//          CM82 combinational stage and captures {f,g,h} into a result register.
// Latency: vector accepted at edge k is presented with out_valid=1 after edge k+1.
//          Backpressure: in_ready = !full; result register holds while out_valid && !out_ready.
// Ports:
//   clk, rst             clock and synchronous active-high reset
//   in_valid/in_ready    upstream handshake, in_vec = {a,b,c,d,e}
//   cm_a..cm_e           FIFO head driven to the CM82 stage (0 when FIFO empty)
//   cm_f, cm_g, cm_h     CM82 stage results, captured on issue
//   out_valid/out_ready  downstream handshake, out_res = {f,g,h}, out_vec = source operands
//   vec_count            number of results delivered (wraps)
//   busy                 FIFO non-empty or result pending
module cm82_vector_sequencer #(
   parameter int DEPTH = 4,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [4:0]       in_vec,
   output logic             cm_a,
   output logic             cm_b,
   output logic             cm_c,
   output logic             cm_d,
   output logic             cm_e,
   input  logic             cm_f,
   input  logic             cm_g,
   input  logic             cm_h,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [2:0]       out_res,
   output logic [4:0]       out_vec,
   output logic [CNT_W-1:0] vec_count,
   output logic             busy
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0]       PTR_ONE = {{AW{1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0]  CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   logic [4:0]       mem_q [DEPTH];
   logic [AW:0]      wr_ptr_q, wr_ptr_d;
   logic [AW:0]      rd_ptr_q, rd_ptr_d;
   logic             out_valid_q, out_valid_d;
   logic [2:0]       out_res_q, out_res_d;
   logic [4:0]       out_vec_q, out_vec_d;
   logic [CNT_W-1:0] vec_count_q, vec_count_d;

   logic             empty, full, push, pop, deliver;
   logic [4:0]       head;

   // Extra pointer MSB separates full (MSBs differ) from empty (pointers equal).
   assign empty = (wr_ptr_q == rd_ptr_q);
   assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                  (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

   assign in_ready = !full;
   assign push     = in_valid && in_ready;
   // Pop depends only on registered occupancy, so a vector pushed into an
   // empty FIFO is never issued on the same edge.
   assign pop      = !empty && (!out_valid_q || out_ready);
   assign deliver  = out_valid_q && out_ready;

   assign head = mem_q[rd_ptr_q[AW-1:0]];
   assign {cm_a, cm_b, cm_c, cm_d, cm_e} = empty ? 5'b0 : head;

   always_comb begin
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      out_valid_d = out_valid_q;
      out_res_d   = out_res_q;
      out_vec_d   = out_vec_q;
      vec_count_d = vec_count_q;

      if (push) begin
         wr_ptr_d = wr_ptr_q + PTR_ONE;
      end

      // A pop on the delivery edge overwrites the old result, keeping out_valid high.
      if (pop) begin
         rd_ptr_d    = rd_ptr_q + PTR_ONE;
         out_valid_d = 1'b1;
         out_res_d   = {cm_f, cm_g, cm_h};
         out_vec_d   = head;
      end else if (deliver) begin
         out_valid_d = 1'b0;
      end

      if (deliver) begin
         vec_count_d = vec_count_q + CNT_ONE;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         out_valid_q <= 1'b0;
         out_res_q   <= '0;
         out_vec_q   <= '0;
         vec_count_q <= '0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         out_valid_q <= out_valid_d;
         out_res_q   <= out_res_d;
         out_vec_q   <= out_vec_d;
         vec_count_q <= vec_count_d;
      end
   end

   // Storage needs no reset: entries are only read between the pointers.
   always_ff @(posedge clk) begin
      if (!rst && push) begin
         mem_q[wr_ptr_q[AW-1:0]] <= in_vec;
      end
   end

   assign out_valid = out_valid_q;
   assign out_res   = out_res_q;
   assign out_vec   = out_vec_q;
   assign vec_count = vec_count_q;
   assign busy      = !empty || out_valid_q;

endmodule

// File: tb/tb_cm82_vector_sequencer.sv
module tb_cm82_vector_sequencer;

   localparam int DEPTH = 4;
   localparam int CNT_W = 4;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             in_valid = 1'b0;
   logic             in_ready;
   logic [4:0]       in_vec = '0;
   logic             cm_a, cm_b, cm_c, cm_d, cm_e;
   logic             cm_f, cm_g, cm_h;
   logic             out_valid;
   logic             out_ready = 1'b0;
   logic [2:0]       out_res;
   logic [4:0]       out_vec;
   logic [CNT_W-1:0] vec_count;
   logic             busy;

   int errors = 0;
   int checks = 0;

   // Scoreboard: {expected result, source vector} pushed on input handshake.
   logic [7:0] sb_q[$];
   int         delivered = 0;
   logic       stall_seen = 1'b0;
   logic [2:0] stall_res;
   logic [4:0] stall_vec;

   always #5 clk = ~clk;

   function automatic logic [2:0] model(input logic [4:0] v);
      return {v[4] ^ v[3] ^ v[2], ~(v[1] ^ v[0]), v[1] | v[0]};
   endfunction

   // CM82 stage model
   assign cm_f = cm_a ^ cm_b ^ cm_c;
   assign cm_g = ~(cm_d ^ cm_e);
   assign cm_h = cm_d | cm_e;

   cm82_vector_sequencer #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready), .in_vec(in_vec),
      .cm_a(cm_a), .cm_b(cm_b), .cm_c(cm_c), .cm_d(cm_d), .cm_e(cm_e),
      .cm_f(cm_f), .cm_g(cm_g), .cm_h(cm_h),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_res(out_res), .out_vec(out_vec),
      .vec_count(vec_count), .busy(busy)
   );

   // Monitor on the falling edge: settled values of the cycle ending at the next rising edge.
   always @(negedge clk) begin
      logic [7:0] exp;
      if (rst) begin
         sb_q.delete();
         delivered  = 0;
         stall_seen = 1'b0;
      end else begin
         checks++;
         if (vec_count !== delivered[CNT_W-1:0]) begin
            errors++;
            $display("FAIL vec_count_track: got %0d expected %0d", vec_count, delivered[CNT_W-1:0]);
         end
         checks++;
         if (busy !== (sb_q.size() != 0)) begin
            errors++;
            $display("FAIL busy_track: got %b expected %b", busy, (sb_q.size() != 0));
         end
         if (stall_seen && out_valid) begin
            checks++;
            if (out_res !== stall_res || out_vec !== stall_vec) begin
               errors++;
               $display("FAIL stall_stable: got res=%b vec=%b expected res=%b vec=%b",
                        out_res, out_vec, stall_res, stall_vec);
            end
         end
         if (out_valid && out_ready) begin
            checks++;
            if (sb_q.size() == 0) begin
               errors++;
               $display("FAIL unexpected_output: got res=%b vec=%b expected none", out_res, out_vec);
            end else begin
               exp = sb_q.pop_front();
               if ({out_res, out_vec} !== exp) begin
                  errors++;
                  $display("FAIL scoreboard: got res=%b vec=%b expected res=%b vec=%b",
                           out_res, out_vec, exp[7:5], exp[4:0]);
               end
            end
            delivered++;
         end
         stall_seen = out_valid && !out_ready;
         stall_res  = out_res;
         stall_vec  = out_vec;
         if (in_valid && in_ready) sb_q.push_back({model(in_vec), in_vec});
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      in_valid = 1'b0;
      out_ready = 1'b0;
      step();
      step();
      rst = 1'b0;
      checks++;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
      checks++;
      if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
      checks++;
      if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
      checks++;
      if (vec_count !== '0) begin errors++; $display("FAIL reset_vec_count: got %0d expected 0", vec_count); end
      checks++;
      if ({cm_a, cm_b, cm_c, cm_d, cm_e} !== 5'b0) begin
         errors++;
         $display("FAIL reset_cm_inputs: got %b expected 00000", {cm_a, cm_b, cm_c, cm_d, cm_e});
      end
      checks++;
      if ({out_res, out_vec} !== 8'b0) begin
         errors++;
         $display("FAIL reset_out_data: got %b expected 0", {out_res, out_vec});
      end
   endtask

   task automatic test_single();
      in_vec = 5'b11010;
      in_valid = 1'b1;
      out_ready = 1'b1;
      step();
      in_valid = 1'b0;
      checks++;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL single_no_bypass: got %b expected 0", out_valid); end
      step();
      checks++;
      if (out_valid !== 1'b1) begin errors++; $display("FAIL single_valid: got %b expected 1", out_valid); end
      checks++;
      if (out_res !== 3'b001) begin errors++; $display("FAIL single_res: got %b expected 001", out_res); end
      checks++;
      if (out_vec !== 5'b11010) begin errors++; $display("FAIL single_vec: got %b expected 11010", out_vec); end
      step();
      checks++;
      if (vec_count !== 4'd1) begin errors++; $display("FAIL single_count: got %0d expected 1", vec_count); end
      checks++;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL single_clear: got %b expected 0", out_valid); end
   endtask

   task automatic test_back_to_back();
      logic [4:0] v [3];
      logic [2:0] r [3];
      v[0] = 5'b00000; v[1] = 5'b10111; v[2] = 5'b11010;
      r[0] = 3'b010;   r[1] = 3'b011;   r[2] = 3'b001;
      out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         in_vec = v[i];
         in_valid = 1'b1;
         step();
         if (i >= 1) begin
            checks++;
            if (out_valid !== 1'b1 || out_res !== r[i-1]) begin
               errors++;
               $display("FAIL b2b_result%0d: got valid=%b res=%b expected valid=1 res=%b",
                        i - 1, out_valid, out_res, r[i-1]);
            end
         end
      end
      in_valid = 1'b0;
      step();
      checks++;
      if (out_valid !== 1'b1 || out_res !== r[2]) begin
         errors++;
         $display("FAIL b2b_result2: got valid=%b res=%b expected valid=1 res=%b", out_valid, out_res, r[2]);
      end
      step();
      checks++;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_drained: got %b expected 0", out_valid); end
   endtask

   task automatic test_backpressure();
      logic [4:0] bp [6];
      int   n;
      int   d0;
      logic acc;
      bp[0] = 5'b10101; bp[1] = 5'b01100; bp[2] = 5'b00011;
      bp[3] = 5'b11111; bp[4] = 5'b01001; bp[5] = 5'b10010;
      n = 0;
      out_ready = 1'b0;
      for (int cyc = 0; cyc < 8; cyc++) begin
         in_vec = bp[(n < 6) ? n : 5];
         in_valid = (n < 6);
         acc = in_valid && in_ready;
         step();
         if (acc) n++;
      end
      checks++;
      if (n != 5) begin errors++; $display("FAIL bp_accepted: got %0d expected 5", n); end
      checks++;
      if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready: got %b expected 0", in_ready); end
      checks++;
      if (out_res !== model(bp[0]) || out_vec !== bp[0]) begin
         errors++;
         $display("FAIL bp_head_held: got res=%b vec=%b expected res=%b vec=%b",
                  out_res, out_vec, model(bp[0]), bp[0]);
      end
      in_valid = 1'b0;
      d0 = delivered;
      out_ready = 1'b1;
      for (int cyc = 0; cyc < 20 && busy; cyc++) step();
      step();
      checks++;
      if (busy !== 1'b0) begin errors++; $display("FAIL bp_drain_timeout: got busy=%b expected 0", busy); end
      checks++;
      if (delivered - d0 != 5) begin errors++; $display("FAIL bp_delivered: got %0d expected 5", delivered - d0); end
   endtask

   task automatic test_wrap();
      int   sent;
      logic acc;
      sent = 0;
      for (int cyc = 0; cyc < 500 && sent < 3 * DEPTH + 1; cyc++) begin
         in_vec = 5'($urandom);
         in_valid = ($urandom_range(0, 3) != 0);
         out_ready = ($urandom_range(0, 1) != 0);
         acc = in_valid && in_ready;
         step();
         if (acc) sent++;
      end
      in_valid = 1'b0;
      checks++;
      if (sent != 3 * DEPTH + 1) begin errors++; $display("FAIL wrap_sent: got %0d expected %0d", sent, 3 * DEPTH + 1); end
      for (int cyc = 0; cyc < 200 && busy; cyc++) begin
         out_ready = ($urandom_range(0, 1) != 0);
         step();
      end
      out_ready = 1'b1;
      step();
      checks++;
      if (busy !== 1'b0 || sb_q.size() != 0) begin
         errors++;
         $display("FAIL wrap_drain: got busy=%b pending=%0d expected busy=0 pending=0", busy, sb_q.size());
      end
   endtask

   task automatic test_reset_mid();
      int   seen;
      out_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         in_vec = 5'(i + 3);
         in_valid = 1'b1;
         step();
      end
      in_valid = 1'b0;
      checks++;
      if (out_valid !== 1'b1 || busy !== 1'b1) begin
         errors++;
         $display("FAIL rstmid_loaded: got valid=%b busy=%b expected 1 1", out_valid, busy);
      end
      rst = 1'b1;
      in_valid = 1'b1;
      in_vec = 5'b11100;
      step();
      rst = 1'b0;
      in_valid = 1'b0;
      checks++;
      if (out_valid !== 1'b0 || busy !== 1'b0 || vec_count !== '0 || in_ready !== 1'b1) begin
         errors++;
         $display("FAIL rstmid_state: got valid=%b busy=%b count=%0d in_ready=%b expected 0 0 0 1",
                  out_valid, busy, vec_count, in_ready);
      end
      out_ready = 1'b1;
      seen = 0;
      for (int cyc = 0; cyc < 8; cyc++) begin
         step();
         if (out_valid) seen++;
      end
      checks++;
      if (seen != 0) begin errors++; $display("FAIL rstmid_ghost: got %0d outputs expected 0", seen); end
   endtask

   task automatic test_counter_wrap();
      int   sent;
      logic acc;
      rst = 1'b1;
      step();
      rst = 1'b0;
      out_ready = 1'b1;
      sent = 0;
      for (int cyc = 0; cyc < 40 && sent < 17; cyc++) begin
         in_vec = 5'(sent * 7);
         in_valid = 1'b1;
         acc = in_valid && in_ready;
         step();
         if (acc) sent++;
      end
      in_valid = 1'b0;
      for (int cyc = 0; cyc < 10 && busy; cyc++) step();
      step();
      checks++;
      if (delivered != 17) begin errors++; $display("FAIL cnt_delivered: got %0d expected 17", delivered); end
      checks++;
      if (vec_count !== 4'd1) begin errors++; $display("FAIL cnt_wrap: got %0d expected 1", vec_count); end
   endtask

   initial begin
      test_reset();
      test_single();
      test_back_to_back();
      test_backpressure();
      test_wrap();
      test_reset_mid();
      test_counter_wrap();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
